// File: rtl/ubfly_s2b_acc_if.sv
// rtl/ubfly_s2b_acc_if.sv - bitstream inputs and binary result outputs of the capture stage
//
// master: drives iEn/iClr/iStart and the four butterfly bitstreams, reads results.
// slave : the capture stage itself.
//   iEn                    cycle enable
//   iClr                   synchronous clear
//   iStart                 capture request (IDLE only)
//   iReal0/iImg0/iReal1/iImg1  butterfly output bitstreams
//   oReal0/oImg0/oReal1/oImg1  offset-binary counts, BITWIDTH bits
//   oValid                 one-cycle result strobe
//   oBusy                  high while skipping or accumulating
interface ubfly_s2b_acc_if #(
    parameter int BITWIDTH = 8
);
    logic                iEn;
    logic                iClr;
    logic                iStart;
    logic                iReal0;
    logic                iImg0;
    logic                iReal1;
    logic                iImg1;
    logic [BITWIDTH-1:0] oReal0;
    logic [BITWIDTH-1:0] oImg0;
    logic [BITWIDTH-1:0] oReal1;
    logic [BITWIDTH-1:0] oImg1;
    logic                oValid;
    logic                oBusy;

    modport master (
        output iEn, iClr, iStart, iReal0, iImg0, iReal1, iImg1,
        input  oReal0, oImg0, oReal1, oImg1, oValid, oBusy
    );

    modport slave (
        input  iEn, iClr, iStart, iReal0, iImg0, iReal1, iImg1,
        output oReal0, oImg0, oReal1, oImg1, oValid, oBusy
    );
endinterface

// File: rtl/ubfly_s2b_acc.sv
// rtl/ubfly_s2b_acc.sv - counts ones of four butterfly bitstreams over a 2^BITWIDTH window
//
// Ports:
//   iClk   clock
//   iRstN  asynchronous active-low reset
//   bus    ubfly_s2b_acc_if slave: enable/clear/start, four input bitstreams,
//          four saturated offset-binary counts, oValid strobe, oBusy
module ubfly_s2b_acc #(
    parameter int BITWIDTH = 8,
    parameter int DELAY    = 2,
    parameter int CONT     = 0
) (
    input  logic            iClk,
    input  logic            iRstN,
    ubfly_s2b_acc_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SKW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [SKW-1:0]    SKIP_LAST = SKW'((DELAY > 0) ? DELAY - 1 : 0);
    localparam logic [BITWIDTH:0] WIN_LAST  = (BITWIDTH + 1)'((1 << BITWIDTH) - 1);

    // A fresh start goes straight to ACC when there is no pipeline fill to skip.
    localparam state_t FIRST_STATE = (DELAY == 0) ? ACC : SKIP;

    state_t                      state_q, state_d;
    logic [SKW-1:0]              skip_cnt_q, skip_cnt_d;
    logic [BITWIDTH:0]           win_cnt_q, win_cnt_d;
    logic [3:0][BITWIDTH:0]      acc_q, acc_d;
    logic [3:0][BITWIDTH-1:0]    res_q, res_d;
    logic [3:0]                  in_bits;

    assign in_bits = {bus.iImg1, bus.iReal1, bus.iImg0, bus.iReal0};

    // A full window of ones gives N, which does not fit; clamp to N-1.
    function automatic logic [BITWIDTH-1:0] sat(input logic [BITWIDTH:0] a);
        return a[BITWIDTH] ? {BITWIDTH{1'b1}} : a[BITWIDTH-1:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        win_cnt_d  = win_cnt_q;
        acc_d      = acc_q;
        res_d      = res_q;

        if (bus.iClr) begin
            state_d    = IDLE;
            skip_cnt_d = '0;
            win_cnt_d  = '0;
            acc_d      = '0;
            res_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.iStart) begin
                        state_d    = FIRST_STATE;
                        skip_cnt_d = '0;
                        win_cnt_d  = '0;
                        acc_d      = '0;
                    end
                end
                SKIP: begin
                    if (bus.iEn) begin
                        skip_cnt_d = skip_cnt_q + 1'b1;
                        if (skip_cnt_q == SKIP_LAST) begin
                            state_d = ACC;
                        end
                    end
                end
                ACC: begin
                    if (bus.iEn) begin
                        for (int i = 0; i < 4; i++) begin
                            acc_d[i] = acc_q[i] + {{BITWIDTH{1'b0}}, in_bits[i]};
                        end
                        win_cnt_d = win_cnt_q + 1'b1;
                        // Results are latched on the last window cycle so they are
                        // already on the outputs during the DONE strobe.
                        if (win_cnt_q == WIN_LAST) begin
                            state_d = DONE;
                            for (int i = 0; i < 4; i++) begin
                                res_d[i] = sat(acc_d[i]);
                            end
                        end
                    end
                end
                DONE: begin
                    if (CONT != 0) begin
                        state_d    = FIRST_STATE;
                        skip_cnt_d = '0;
                        win_cnt_d  = '0;
                        acc_d      = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q    <= IDLE;
            skip_cnt_q <= '0;
            win_cnt_q  <= '0;
            acc_q      <= '0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            win_cnt_q  <= win_cnt_d;
            acc_q      <= acc_d;
            res_q      <= res_d;
        end
    end

    assign bus.oReal0 = res_q[0];
    assign bus.oImg0  = res_q[1];
    assign bus.oReal1 = res_q[2];
    assign bus.oImg1  = res_q[3];
    assign bus.oValid = (state_q == DONE);
    assign bus.oBusy  = (state_q == SKIP) || (state_q == ACC);
endmodule

// File: tb/tb_ubfly_s2b_acc.sv
// tb/tb_ubfly_s2b_acc.sv - directed self-checking bench for ubfly_s2b_acc
module tb_ubfly_s2b_acc;
    logic iClk  = 1'b0;
    logic iRstN = 1'b0;

    always #5 iClk = ~iClk;

    ubfly_s2b_acc_if #(.BITWIDTH(4)) bus0 ();
    ubfly_s2b_acc_if #(.BITWIDTH(4)) bus1 ();

    ubfly_s2b_acc #(.BITWIDTH(4), .DELAY(2), .CONT(0)) u_dut (
        .iClk  (iClk),
        .iRstN (iRstN),
        .bus   (bus0.slave)
    );

    ubfly_s2b_acc #(.BITWIDTH(4), .DELAY(2), .CONT(1)) u_cont (
        .iClk  (iClk),
        .iRstN (iRstN),
        .bus   (bus1.slave)
    );

    int total = 0;
    int bad   = 0;

    int v_cyc, v_cnt, b_first, b_last, b_cnt;
    logic [15:0] o_res;

    task automatic idle_inputs();
        bus0.iEn = 1'b1; bus0.iClr = 1'b0; bus0.iStart = 1'b0;
        bus0.iReal0 = 1'b0; bus0.iImg0 = 1'b0; bus0.iReal1 = 1'b0; bus0.iImg1 = 1'b0;
        bus1.iEn = 1'b1; bus1.iClr = 1'b0; bus1.iStart = 1'b0;
        bus1.iReal0 = 1'b0; bus1.iImg0 = 1'b0; bus1.iReal1 = 1'b0; bus1.iImg1 = 1'b0;
    endtask

    // Drives one 45-cycle scenario on bus0, starting just after a rising edge.
    // mode 0: all ones; 1: mixed patterns; 2: ones only in SKIP;
    // 3: iEn low cycles 8..12; 4: iStart again at 5, iClr at 10.
    task automatic run_mode(input int mode);
        v_cyc = -1; v_cnt = 0; b_first = -1; b_last = -1; b_cnt = 0; o_res = '0;
        for (int c = 0; c < 45; c++) begin
            bus0.iStart = (c == 0) || (mode == 4 && c == 5);
            bus0.iClr   = (mode == 4 && c == 10);
            bus0.iEn    = !(mode == 3 && c >= 8 && c <= 12);
            case (mode)
                1: begin
                    bus0.iReal0 = (c % 2 == 0);
                    bus0.iImg0  = 1'b0;
                    bus0.iReal1 = 1'b1;
                    bus0.iImg1  = ((c % 4) < 2);
                end
                2: begin
                    bus0.iReal0 = (c <= 2); bus0.iImg0 = (c <= 2);
                    bus0.iReal1 = (c <= 2); bus0.iImg1 = (c <= 2);
                end
                3: begin
                    bus0.iReal0 = 1'b1;
                    bus0.iImg0  = (c >= 8 && c <= 12);
                    bus0.iReal1 = 1'b1;
                    bus0.iImg1  = 1'b0;
                end
                default: begin
                    bus0.iReal0 = 1'b1; bus0.iImg0 = 1'b1;
                    bus0.iReal1 = 1'b1; bus0.iImg1 = 1'b1;
                end
            endcase
            @(negedge iClk);
            if (bus0.oBusy) begin
                if (b_first < 0) b_first = c;
                b_last = c;
                b_cnt++;
            end
            if (bus0.oValid) begin
                v_cnt++;
                if (v_cyc < 0) begin
                    v_cyc = c;
                    o_res = {bus0.oReal0, bus0.oImg0, bus0.oReal1, bus0.oImg1};
                end
            end
            @(posedge iClk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        iRstN = 1'b0;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        total++;
        if (bus0.oValid !== 1'b0 || bus0.oBusy !== 1'b0) begin
            bad++; $display("FAIL reset_flags valid=%b busy=%b required 0 0", bus0.oValid, bus0.oBusy);
        end
        total++;
        if ({bus0.oReal0, bus0.oImg0, bus0.oReal1, bus0.oImg1} !== 16'h0000) begin
            bad++; $display("FAIL reset_outputs got=%h required=0000",
                            {bus0.oReal0, bus0.oImg0, bus0.oReal1, bus0.oImg1});
        end
        total++;
        if (bus1.oValid !== 1'b0 || bus1.oBusy !== 1'b0) begin
            bad++; $display("FAIL reset_cont_flags valid=%b busy=%b required 0 0", bus1.oValid, bus1.oBusy);
        end
        iRstN = 1'b1;
        @(posedge iClk); #1;
    endtask

    task automatic test_all_ones();
        run_mode(0);
        total++;
        if (v_cyc !== 19 || v_cnt !== 1) begin
            bad++; $display("FAIL ones_valid cycle=%0d count=%0d required 19 1", v_cyc, v_cnt);
        end
        total++;
        if (b_first !== 1 || b_last !== 18 || b_cnt !== 18) begin
            bad++; $display("FAIL ones_busy first=%0d last=%0d n=%0d required 1 18 18", b_first, b_last, b_cnt);
        end
        total++;
        if (o_res !== 16'hFFFF) begin
            bad++; $display("FAIL ones_saturate got=%h required=ffff", o_res);
        end
    endtask

    task automatic test_patterns();
        run_mode(1);
        total++;
        if (v_cyc !== 19) begin
            bad++; $display("FAIL pattern_valid cycle=%0d required 19", v_cyc);
        end
        total++;
        if (o_res !== 16'h80F8) begin
            bad++; $display("FAIL pattern_counts got=%h required=80f8", o_res);
        end
    endtask

    task automatic test_skip_discard();
        run_mode(2);
        total++;
        if (v_cyc !== 19 || o_res !== 16'h0000) begin
            bad++; $display("FAIL skip_discard cycle=%0d got=%h required 19 0000", v_cyc, o_res);
        end
    endtask

    task automatic test_en_pause();
        run_mode(3);
        total++;
        if (v_cyc !== 24 || b_last !== 23) begin
            bad++; $display("FAIL pause_timing valid=%0d busy_last=%0d required 24 23", v_cyc, b_last);
        end
        total++;
        if (o_res !== 16'hF0F0) begin
            bad++; $display("FAIL pause_counts got=%h required=f0f0", o_res);
        end
    endtask

    task automatic test_clear();
        run_mode(4);
        total++;
        if (v_cnt !== 0) begin
            bad++; $display("FAIL clr_no_strobe strobes=%0d required 0", v_cnt);
        end
        total++;
        if (b_first !== 1 || b_last !== 10 || b_cnt !== 10) begin
            bad++; $display("FAIL clr_busy first=%0d last=%0d n=%0d required 1 10 10", b_first, b_last, b_cnt);
        end
        total++;
        if ({bus0.oReal0, bus0.oImg0, bus0.oReal1, bus0.oImg1} !== 16'h0000) begin
            bad++; $display("FAIL clr_outputs got=%h required=0000",
                            {bus0.oReal0, bus0.oImg0, bus0.oReal1, bus0.oImg1});
        end
        run_mode(0);
        total++;
        if (v_cyc !== 19 || o_res !== 16'hFFFF) begin
            bad++; $display("FAIL clr_restart cycle=%0d got=%h required 19 ffff", v_cyc, o_res);
        end
    endtask

    task automatic test_async_reset();
        bus0.iStart = 1'b1;
        @(posedge iClk); #1;
        bus0.iStart = 1'b0;
        bus0.iReal0 = 1'b1;
        repeat (7) begin
            @(posedge iClk); #1;
        end
        total++;
        if (bus0.oBusy !== 1'b1) begin
            bad++; $display("FAIL arst_pre busy=%b required 1", bus0.oBusy);
        end
        #2 iRstN = 1'b0;
        #1;
        total++;
        if (bus0.oBusy !== 1'b0 || {bus0.oReal0, bus0.oImg0, bus0.oReal1, bus0.oImg1} !== 16'h0000) begin
            bad++; $display("FAIL arst_abort busy=%b out=%h required 0 0000", bus0.oBusy,
                            {bus0.oReal0, bus0.oImg0, bus0.oReal1, bus0.oImg1});
        end
        @(negedge iClk);
        iRstN = 1'b1;
        idle_inputs();
        @(posedge iClk); #1;
    endtask

    task automatic test_cont();
        int vc;
        int low_cnt;
        logic low19, low38;
        logic [15:0] r19, r38;
        vc = 0; low_cnt = 0; low19 = 1'b0; low38 = 1'b0; r19 = 'x; r38 = 'x;
        for (int c = 0; c < 41; c++) begin
            bus1.iStart = (c == 0);
            bus1.iEn    = 1'b1;
            bus1.iReal0 = (c <= 19); bus1.iImg0 = (c <= 19);
            bus1.iReal1 = (c <= 19); bus1.iImg1 = (c <= 19);
            @(negedge iClk);
            if (c >= 1 && c <= 38 && !bus1.oBusy) begin
                low_cnt++;
                if (c == 19) low19 = 1'b1;
                if (c == 38) low38 = 1'b1;
            end
            if (bus1.oValid) begin
                vc++;
                if (c == 19) r19 = {bus1.oReal0, bus1.oImg0, bus1.oReal1, bus1.oImg1};
                if (c == 38) r38 = {bus1.oReal0, bus1.oImg0, bus1.oReal1, bus1.oImg1};
            end
            @(posedge iClk); #1;
        end
        total++;
        if (vc !== 2 || r19 !== 16'hFFFF || r38 !== 16'h0000) begin
            bad++; $display("FAIL cont_strobes n=%0d r19=%h r38=%h required 2 ffff 0000", vc, r19, r38);
        end
        total++;
        if (low_cnt !== 2 || !low19 || !low38) begin
            bad++; $display("FAIL cont_busy low_n=%0d at19=%b at38=%b required 2 1 1", low_cnt, low19, low38);
        end
        bus1.iClr = 1'b1;
        @(posedge iClk); #1;
        bus1.iClr = 1'b0;
        @(negedge iClk);
        total++;
        if (bus1.oBusy !== 1'b0 || bus1.oValid !== 1'b0) begin
            bad++; $display("FAIL cont_clr busy=%b valid=%b required 0 0", bus1.oBusy, bus1.oValid);
        end
        idle_inputs();
        @(posedge iClk); #1;
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_patterns();
        test_skip_discard();
        test_en_pause();
        test_clear();
        test_async_reset();
        test_cont();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
